blade_launcher: RTL

- Fire controller sitting between the player's fire button and a pool of NUM_SLOTS blade instances.
- Edge-detects the button and enforces a cooldown plus a regenerating charge budget.
- Picks the lowest-index inactive blade slot and drives its shoot input with an acknowledged handshake; the ack is the slot's isActive bit (bit 0 of its 27-bit bladeState).
- Sits in the player/projectile layer, clocked by sim_clk.

---
 rtl/blade_launcher_if.sv | 30 +++
 rtl/blade_launcher.sv | 125 ++++++++++++
 2 files changed

// File: rtl/blade_launcher_if.sv
// Fire-button / blade-slot signal bundle; slave side is the launcher, master side the player/blade pool.
// No buffering: plain wires, one driver per signal.
interface blade_launcher_if #(
  parameter int NUM_SLOTS = 2
) ();
  logic                 fire_btn;
  logic [NUM_SLOTS-1:0] slot_active;
  logic [NUM_SLOTS-1:0] shoot;
  logic [2:0]           charges;
  logic                 busy;
  logic                 denied;

  modport slave (
    input  fire_btn,
    input  slot_active,
    output shoot,
    output charges,
    output busy,
    output denied
  );

  modport master (
    output fire_btn,
    output slot_active,
    input  shoot,
    input  charges,
    input  busy,
    input  denied
  );
endinterface

// File: rtl/blade_launcher.sv
// Edge-triggered blade fire controller with cooldown and regenerating charges; shoot rises 1 cycle after the button edge.
// No backpressure: presses that cannot be served produce a one-cycle denied pulse and are never queued.
module blade_launcher #(
  parameter int NUM_SLOTS   = 2,
  parameter int COOLDOWN    = 12,
  parameter int MAX_CHARGES = 3,
  parameter int RECHARGE    = 60,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic             sim_clk,
  input  logic             reset,
  blade_launcher_if.slave  bus
);
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {S_READY, S_FIRE, S_COOL} state_t;

  state_t               state;
  logic                 btn_q;
  logic [CW-1:0]        cd_cnt;
  logic [TW-1:0]        to_cnt;
  logic [7:0]           rc_cnt;
  logic [NUM_SLOTS-1:0] shoot_r;
  logic [2:0]           charges_r;
  logic                 busy_r;
  logic                 denied_r;

  logic                 fire_req;
  logic                 free;
  logic [NUM_SLOTS-1:0] tgt_oh;
  logic                 ack;
  logic                 spend;
  logic                 regen;
  logic                 full;

  always_comb begin
    fire_req = bus.fire_btn & ~btn_q;
    tgt_oh   = '0;
    free     = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!free && !bus.slot_active[i]) begin
        tgt_oh[i] = 1'b1;
        free      = 1'b1;
      end
    end
    // shoot stays one-hot on the latched target for the whole FIRE state
    ack   = |(bus.slot_active & shoot_r);
    spend = (state == S_FIRE) && ack;
    full  = (charges_r == 3'(MAX_CHARGES));
    regen = !full && (rc_cnt == 8'(RECHARGE - 1));
  end

  always_ff @(posedge sim_clk) begin
    if (reset) begin
      state     <= S_READY;
      btn_q     <= 1'b1;
      cd_cnt    <= '0;
      to_cnt    <= '0;
      rc_cnt    <= '0;
      shoot_r   <= '0;
      charges_r <= 3'(MAX_CHARGES);
      busy_r    <= 1'b0;
      denied_r  <= 1'b0;
    end else begin
      btn_q    <= bus.fire_btn;
      denied_r <= 1'b0;

      if (full || regen) rc_cnt <= '0;
      else               rc_cnt <= rc_cnt + 8'd1;

      // a spend and a regen on the same edge cancel out
      if (spend && !regen)      charges_r <= charges_r - 3'd1;
      else if (regen && !spend) charges_r <= charges_r + 3'd1;

      case (state)
        S_READY: begin
          if (fire_req) begin
            if (free && charges_r != 3'd0) begin
              shoot_r <= tgt_oh;
              to_cnt  <= '0;
              state   <= S_FIRE;
              busy_r  <= 1'b1;
            end else begin
              denied_r <= 1'b1;
            end
          end
        end
        S_FIRE: begin
          if (ack) begin
            shoot_r <= '0;
            cd_cnt  <= CW'(COOLDOWN - 1);
            state   <= S_COOL;
          end else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
            shoot_r  <= '0;
            denied_r <= 1'b1;
            state    <= S_READY;
            busy_r   <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_COOL: begin
          if (fire_req) denied_r <= 1'b1;
          if (cd_cnt == '0) begin
            state  <= S_READY;
            busy_r <= 1'b0;
          end else begin
            cd_cnt <= cd_cnt - 1'b1;
          end
        end
        default: begin
          state   <= S_READY;
          shoot_r <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.shoot   = shoot_r;
  assign bus.charges = charges_r;
  assign bus.busy    = busy_r;
  assign bus.denied  = denied_r;
endmodule
